// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered digits committed at frame
// boundaries, leading-zero blanking and per-slot PWM brightness.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [3:0]              bright,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int SW   = $clog2(REFRESH_DIV);
    localparam int CW   = SW + 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP = REFRESH_DIV / 16;

    logic [SW-1:0]                slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [3:0]                   bright_s_q, bright_s_d;
    logic [NUM_DIGITS-1:0][3:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0][3:0]   active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]        active_dp_q, active_dp_d;
    logic                         pending_q, pending_d;
    logic                         frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         dp_n_q, dp_n_d;

    logic          slot_wrap, idx_last, frame_end, commit;
    logic          slot_on, blanked, lit;
    logic [CW-1:0] on_thr;
    logic [3:0]    nib;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_wrap  = (slot_cnt_q == SW'(REFRESH_DIV - 1));
        idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
        frame_end  = slot_wrap && idx_last;
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end

        // Brightness is latched at slot start so one slot never mixes two duty cycles.
        bright_s_d = (slot_cnt_q == '0) ? bright : bright_s_q;
        on_thr     = CW'((32'(bright_s_d) + 32'd1) * STEP);
        slot_on    = ({1'b0, slot_cnt_q} < on_thr);

        nib     = active_val_q[idx_q];
        blanked = blank_lz && (idx_q != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx_q) && active_val_q[k] != 4'd0) begin
                blanked = 1'b0;
            end
        end
        lit = slot_on && !blanked;

        an_d = '1;
        if (slot_on) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d  = lit ? hex_glyph(nib) : 7'h7F;
        dp_n_d = lit ? ~active_dp_q[idx_q] : 1'b1;

        // A load coinciding with the boundary commits the old shadow and stays pending.
        commit       = frame_end && pending_q;
        active_val_d = commit ? shadow_val_q : active_val_q;
        active_dp_d  = commit ? shadow_dp_q : active_dp_q;
        shadow_val_d = load ? value : shadow_val_q;
        shadow_dp_d  = load ? dp : shadow_dp_q;
        pending_d    = load || (pending_q && !frame_end);
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            bright_s_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_n_q       <= 1'b1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            bright_s_q   <= bright_s_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a time-indexed reference model.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 16;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  bright = 4'd15;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;
    logic        pending;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
        .blank_lz(blank_lz), .bright(bright), .seg(seg), .dp_n(dp_n),
        .an(an), .frame_tick(frame_tick), .pending(pending)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: scan position derived from elapsed cycles since reset
    int          t = 0;
    logic [15:0] m_act = '0, m_sh = '0;
    logic [3:0]  m_act_dp = '0, m_sh_dp = '0;
    bit          m_pend = 1'b0;
    int          m_bs = 0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn, e_ft, e_pend;

    task automatic step();
        int slot, d;
        bit fb, on, blank;
        logic [3:0] nib;
        if (rst) begin
            t = 0; m_act = '0; m_sh = '0; m_act_dp = '0; m_sh_dp = '0; m_pend = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_ft = 1'b0;
        end else begin
            slot = t % RD;
            d    = (t / RD) % ND;
            fb   = ((t % FRAME) == FRAME - 1);
            if (slot == 0) m_bs = int'(bright);
            on    = (slot < (m_bs + 1) * (RD / 16));
            blank = blank_lz && (d > 0) && ((m_act >> (4 * d)) == 16'd0);
            nib   = m_act[4*d +: 4];
            e_an  = on ? ~(4'b0001 << d) : 4'hF;
            e_seg = (on && !blank) ? glyph[nib] : 7'h7F;
            e_dpn = (on && !blank) ? ~m_act_dp[d] : 1'b1;
            e_ft  = fb;
            if (fb && m_pend) begin
                m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
            end
            if (load) begin
                m_sh = value; m_sh_dp = dp; m_pend = 1'b1;
            end
            t++;
        end
        e_pend = m_pend;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dpn));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        check("pending", 32'(pending), 32'(e_pend));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic wait_tick(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            step();
            got = frame_tick;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    logic [6:0] cap_seg [ND];
    int         cap_low [ND];
    int         cap_ticks;

    task automatic capture_frame();
        cap_ticks = 0;
        for (int k = 0; k < ND; k++) begin
            cap_seg[k] = 7'h55;
            cap_low[k] = 0;
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (frame_tick) cap_ticks++;
            for (int k = 0; k < ND; k++) begin
                if (an[k] === 1'b0) begin
                    cap_low[k]++;
                    cap_seg[k] = seg;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (10) begin
            step();
            check("rst_an", 32'(an), 32'hF);
            check("rst_seg", 32'(seg), 32'h7F);
        end
        rst = 1'b0;
        step();
        check("first_an", 32'(an), 32'hE);

        // Mixed digits with a blanked leading zero
        blank_lz = 1'b1; value = 16'h070A; dp = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        wait_tick("tick_070a");
        capture_frame();
        check("d0_070a", 32'(cap_seg[0]), 32'h08);
        check("d1_070a", 32'(cap_seg[1]), 32'h40);
        check("d2_070a", 32'(cap_seg[2]), 32'h78);
        check("d3_070a", 32'(cap_seg[3]), 32'h7F);
        check("d3_an_slots", 32'(cap_low[3]), 32'd16);

        // Last load in a frame wins
        value = 16'h000A; load = 1'b1; step(); load = 1'b0;
        step(); step();
        value = 16'h0007; load = 1'b1; step(); load = 1'b0;
        check("pend_041", 32'(pending), 32'd1);
        wait_tick("tick_041");
        check("pend_041_clr", 32'(pending), 32'd0);
        capture_frame();
        check("d0_0007", 32'(cap_seg[0]), 32'h78);
        check("d1_0007", 32'(cap_seg[1]), 32'h7F);
        check("d2_0007", 32'(cap_seg[2]), 32'h7F);
        check("d3_0007", 32'(cap_seg[3]), 32'h7F);
        check("ticks_041", 32'(cap_ticks), 32'd1);

        // Duty cycle at low brightness
        bright = 4'd3;
        capture_frame();
        for (int k = 0; k < ND; k++) check($sformatf("duty3_an%0d", k), 32'(cap_low[k]), 32'd4);
        bright = 4'd0;
        capture_frame();
        for (int k = 0; k < ND; k++) check($sformatf("duty0_an%0d", k), 32'(cap_low[k]), 32'd1);
        bright = 4'd15;

        // Load landing exactly on the frame boundary
        value = 16'h0001; load = 1'b1; step(); load = 1'b0;
        while ((t % FRAME) != FRAME - 1) step();
        value = 16'h0008; load = 1'b1; step(); load = 1'b0;
        check("pend_043", 32'(pending), 32'd1);
        check("tick_043", 32'(frame_tick), 32'd1);
        capture_frame();
        check("d0_old_043", 32'(cap_seg[0]), 32'h79);
        check("pend_043_clr", 32'(pending), 32'd0);
        capture_frame();
        check("d0_new_043", 32'(cap_seg[0]), 32'h00);

        // Reset discards a pending load
        repeat (20) step();
        value = 16'h1234; load = 1'b1; step(); load = 1'b0;
        check("pend_044", 32'(pending), 32'd1);
        repeat (5) step();
        rst = 1'b1; step(); step();
        check("pend_044_rst", 32'(pending), 32'd0);
        rst = 1'b0; blank_lz = 1'b0;
        capture_frame();
        capture_frame();
        for (int k = 0; k < ND; k++) check($sformatf("d%0d_044", k), 32'(cap_seg[k]), 32'h40);

        // Random traffic
        repeat (3000) begin
            load  = ($urandom_range(15, 0) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            if ($urandom_range(49, 0) == 0) bright = 4'($urandom);
            if ($urandom_range(99, 0) == 0) blank_lz = 1'($urandom);
            rst = ($urandom_range(699, 0) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
